// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - N-master to 1-slave AXI read arbiter, single outstanding burst.
// Define AXI_RD_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module axi_rd_arbiter #(
  parameter int NUM_M     = 2,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter int IDX_BITS  = $clog2(NUM_M)
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_M*ID_BITS-1:0]      M_ARID,
  input  logic [NUM_M*ADDR_BITS-1:0]    M_ARADDR,
  input  logic [NUM_M*LEN_BITS-1:0]     M_ARLEN,
  input  logic [NUM_M*SIZE_BITS-1:0]    M_ARSIZE,
  input  logic [NUM_M*2-1:0]            M_ARBURST,
  input  logic [NUM_M-1:0]              M_ARVALID,
  output logic [NUM_M-1:0]              M_ARREADY,
  output logic [NUM_M*ID_BITS-1:0]      M_RID,
  output logic [NUM_M*DATA_BITS-1:0]    M_RDATA,
  output logic [NUM_M*2-1:0]            M_RRESP,
  output logic [NUM_M-1:0]              M_RLAST,
  output logic [NUM_M-1:0]              M_RVALID,
  input  logic [NUM_M-1:0]              M_RREADY,
  output logic [IDX_BITS+ID_BITS-1:0]   S_ARID,
  output logic [ADDR_BITS-1:0]          S_ARADDR,
  output logic [LEN_BITS-1:0]           S_ARLEN,
  output logic [SIZE_BITS-1:0]          S_ARSIZE,
  output logic [1:0]                    S_ARBURST,
  output logic                          S_ARVALID,
  input  logic                          S_ARREADY,
  input  logic [IDX_BITS+ID_BITS-1:0]   S_RID,
  input  logic [DATA_BITS-1:0]          S_RDATA,
  input  logic [1:0]                    S_RRESP,
  input  logic                          S_RLAST,
  input  logic                          S_RVALID,
  output logic                          S_RREADY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state_q;
  logic [IDX_BITS-1:0]   grant_q;
  logic [IDX_BITS-1:0]   rr_ptr_q;
  logic [IDX_BITS-1:0]   rr_ptr_d;
  logic [IDX_BITS-1:0]   pick;
  logic                  found;
  int                    arb_idx;
  logic                  ar_hs;
  logic                  r_last_hs;
  logic                  unused_ok;

  // Routing is by grant alone, so the index echoed in the upper RID bits is ignored.
  assign unused_ok = ^{S_RID[IDX_BITS+ID_BITS-1:ID_BITS], rr_ptr_q};

  always_comb begin
    pick    = '0;
    found   = 1'b0;
    arb_idx = 0;
    for (int k = 0; k < NUM_M; k++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      arb_idx = k;
`else
      arb_idx = (int'(rr_ptr_q) + k) % NUM_M;
`endif
      if (!found && M_ARVALID[arb_idx]) begin
        found = 1'b1;
        pick  = IDX_BITS'(arb_idx);
      end
    end
  end

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  assign rr_ptr_d = '0;
`else
  assign rr_ptr_d = (grant_q == IDX_BITS'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
`endif

  assign ar_hs     = S_ARVALID & S_ARREADY;
  assign r_last_hs = S_RVALID & S_RREADY & S_RLAST;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= pick;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) state_q <= DATA;
        end
        DATA: begin
          if (r_last_hs) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Everything outside the owning phase is forced to zero, including non-granted R data.
  always_comb begin
    M_ARREADY = '0;
    M_RID     = '0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    M_RLAST   = '0;
    M_RVALID  = '0;
    S_ARID    = '0;
    S_ARADDR  = '0;
    S_ARLEN   = '0;
    S_ARSIZE  = '0;
    S_ARBURST = '0;
    S_ARVALID = 1'b0;
    S_RREADY  = 1'b0;
    case (state_q)
      ADDR: begin
        S_ARID             = {grant_q, M_ARID[grant_q*ID_BITS +: ID_BITS]};
        S_ARADDR           = M_ARADDR[grant_q*ADDR_BITS +: ADDR_BITS];
        S_ARLEN            = M_ARLEN[grant_q*LEN_BITS +: LEN_BITS];
        S_ARSIZE           = M_ARSIZE[grant_q*SIZE_BITS +: SIZE_BITS];
        S_ARBURST          = M_ARBURST[grant_q*2 +: 2];
        S_ARVALID          = M_ARVALID[grant_q];
        M_ARREADY[grant_q] = S_ARREADY;
      end
      DATA: begin
        M_RVALID[grant_q]                    = S_RVALID;
        S_RREADY                             = M_RREADY[grant_q];
        M_RID[grant_q*ID_BITS +: ID_BITS]    = S_RID[ID_BITS-1:0];
        M_RDATA[grant_q*DATA_BITS +: DATA_BITS] = S_RDATA;
        M_RRESP[grant_q*2 +: 2]              = S_RRESP;
        M_RLAST[grant_q]                     = S_RLAST;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter.
// Honours AXI_RD_ARB_FIXED_PRIO_EN when predicting grants.
module tb_axi_rd_arbiter;
  localparam int NM  = 2;
  localparam int IDB = 4;
  localparam int AB  = 32;
  localparam int DB  = 32;
  localparam int LB  = 4;
  localparam int SB  = 3;
  localparam int IX  = $clog2(NM);

  logic clk = 1'b0;
  logic rstn;
  logic [NM*IDB-1:0] m_arid;
  logic [NM*AB-1:0]  m_araddr;
  logic [NM*LB-1:0]  m_arlen;
  logic [NM*SB-1:0]  m_arsize;
  logic [NM*2-1:0]   m_arburst;
  logic [NM-1:0]     m_arvalid, m_arready;
  logic [NM*IDB-1:0] m_rid;
  logic [NM*DB-1:0]  m_rdata;
  logic [NM*2-1:0]   m_rresp;
  logic [NM-1:0]     m_rlast, m_rvalid, m_rready;
  logic [IX+IDB-1:0] s_arid, s_rid;
  logic [AB-1:0]     s_araddr;
  logic [LB-1:0]     s_arlen;
  logic [SB-1:0]     s_arsize;
  logic [1:0]        s_arburst, s_rresp;
  logic              s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [DB-1:0]     s_rdata;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.NUM_M(NM), .ID_BITS(IDB), .ADDR_BITS(AB), .DATA_BITS(DB),
                   .LEN_BITS(LB), .SIZE_BITS(SB)) dut (
    .ACLK(clk), .ARESETn(rstn),
    .M_ARID(m_arid), .M_ARADDR(m_araddr), .M_ARLEN(m_arlen), .M_ARSIZE(m_arsize),
    .M_ARBURST(m_arburst), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
    .M_RID(m_rid), .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RLAST(m_rlast),
    .M_RVALID(m_rvalid), .M_RREADY(m_rready),
    .S_ARID(s_arid), .S_ARADDR(s_araddr), .S_ARLEN(s_arlen), .S_ARSIZE(s_arsize),
    .S_ARBURST(s_arburst), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
    .S_RID(s_rid), .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RLAST(s_rlast),
    .S_RVALID(s_rvalid), .S_RREADY(s_rready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [IDB-1:0] id, input logic [AB-1:0] addr,
                         input int len);
    m_arid[m*IDB +: IDB]  = id;
    m_araddr[m*AB +: AB]  = addr;
    m_arlen[m*LB +: LB]   = LB'(len);
    m_arsize[m*SB +: SB]  = SB'($urandom);
    m_arburst[m*2 +: 2]   = 2'($urandom);
    m_arvalid[m]          = 1'b1;
  endtask

  task automatic clear_inputs();
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_arvalid = '0; m_rready = '0;
    s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
  endtask

  // Called right after inputs are driven at a falling edge; acts as the slave for one burst.
  task automatic do_txn(input int exp_m, input int exp_wait, input int ar_delay, input bit gaps,
                        input int hold_mask, input int abort_at);
    int waits, b, cyc;
    bit rv, rr, held;
    logic [IDB-1:0] id;
    logic [LB-1:0] len;
    logic [IX+IDB-1:0] e_arid;
    id = m_arid[exp_m*IDB +: IDB];
    len = m_arlen[exp_m*LB +: LB];
    e_arid = {IX'(exp_m), id};
    waits = 0;
    #1;
    while (!s_arvalid && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    chk("ar_latency", 64'(waits), 64'(exp_wait));
    if (!s_arvalid) return;
    chk("s_araddr", s_araddr, m_araddr[exp_m*AB +: AB]);
    chk("s_arlen", s_arlen, len);
    chk("s_arsize_burst", {s_arsize, s_arburst}, {m_arsize[exp_m*SB +: SB], m_arburst[exp_m*2 +: 2]});
    for (int k = 0; k < ar_delay; k++) begin
      chk("s_arid_stall", s_arid, e_arid);
      chk("m_arready_stall", m_arready, '0);
      @(negedge clk); #1;
    end
    chk("s_arid", s_arid, e_arid);
    s_arready = 1'b1;
    #1;
    chk("m_arready", m_arready, NM'(1) << exp_m);
    @(negedge clk);
    s_arready = 1'b0;
    m_arvalid[exp_m] = 1'b0;
    b = 0; cyc = 0; held = 1'b0;
    while (b <= int'(len) && cyc < 200) begin
      rv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rr = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (hold_mask[b] && !held && rv) begin
        rr = 1'b0;
        held = 1'b1;
      end
      m_rready = NM'($urandom);
      m_rready[exp_m] = rr;
      s_rvalid = rv;
      s_rdata = DB'($urandom);
      s_rresp = 2'($urandom);
      s_rlast = (b == int'(len));
      s_rid = {IX'($urandom), id};
      if (b == abort_at) return;
      #1;
      chk("m_rvalid", m_rvalid, NM'(rv) << exp_m);
      chk("s_rready", s_rready, rr);
      chk("m_arready_data", m_arready, '0);
      chk("m_rdata", m_rdata[exp_m*DB +: DB], s_rdata);
      chk("m_rid_last_resp", {m_rid[exp_m*IDB +: IDB], m_rlast[exp_m], m_rresp[exp_m*2 +: 2]},
          {id, s_rlast, s_rresp});
      for (int i = 0; i < NM; i++)
        if (i != exp_m)
          chk("other_r_zero", {m_rdata[i*DB +: DB], m_rid[i*IDB +: IDB], m_rresp[i*2 +: 2], m_rlast[i]}, '0);
      if (rv && rr) begin
        b++;
        held = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("beats", 64'(b), 64'(int'(len) + 1));
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    #1;
    chk("idle_gap", {s_arvalid, m_rvalid, s_rready}, '0);
  endtask

  typedef struct {
    logic [NM-1:0] req;
    int            len;
    int            exp_rr;
    int            exp_fx;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit pend[NM];
    int rrm, exp_m, any;
    vecs[0] = '{2'b01, 0, 0, 0};
    vecs[1] = '{2'b11, 3, 1, 0};
    vecs[2] = '{2'b11, 3, 0, 0};
    vecs[3] = '{2'b11, 3, 1, 0};
    vecs[4] = '{2'b10, 1, 1, 1};
    vecs[5] = '{2'b01, 0, 0, 0};
    vecs[6] = '{2'b01, 2, 0, 0};
    vecs[7] = '{2'b11, 0, 1, 0};
    vecs[8] = '{2'b11, 0, 0, 0};

    clear_inputs();
    rstn = 1'b0;
    m_arvalid = '1;
    s_rvalid = 1'b1;
    m_rready = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ar", {s_arvalid, m_arready, s_araddr}, '0);
    chk("rst_r", {m_rvalid, s_rready, m_rdata}, '0);
    clear_inputs();
    rstn = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 9; r++) begin
      m_arvalid = '0;
      for (int m = 0; m < NM; m++)
        if (vecs[r].req[m])
          set_req(m, (m == 0) ? 4'h3 : 4'hA, (m == 0) ? 32'h10 : 32'h2000_0040 + 32'(r), vecs[r].len);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      do_txn(vecs[r].exp_fx, 1, r % 3, 1'b0, 0, -1);
`else
      do_txn(vecs[r].exp_rr, 1, r % 3, 1'b0, 0, -1);
`endif
    end
    m_arvalid = '0;

    // AR stall while the other master raises ARVALID
    set_req(0, 4'h5, 32'h100, 1);
    @(negedge clk);
    set_req(1, 4'h6, 32'h200, 0);
    do_txn(0, 0, 5, 1'b0, 0, -1);
    do_txn(1, 1, 0, 1'b0, 0, -1);

    // long burst with slave gaps and owner back-pressure on beats 2 and 5
    set_req(1, 4'h9, 32'h300, 7);
    do_txn(1, 1, 0, 1'b1, 32'h24, -1);

    // reset mid-burst, after an M0 burst has moved the pointer to M1
    set_req(0, 4'h1, 32'h400, 0);
    do_txn(0, 1, 0, 1'b0, 0, -1);
    set_req(1, 4'h2, 32'h500, 3);
    do_txn(1, 1, 0, 1'b0, 0, 2);
    rstn = 1'b0;
    set_req(0, 4'h7, 32'h600, 0);
    set_req(1, 4'h8, 32'h700, 0);
    @(negedge clk);
    #1;
    chk("midrst_ar", {s_arvalid, m_arready, s_arid, s_araddr}, '0);
    chk("midrst_r", {m_rvalid, s_rready, m_rlast, m_rid, m_rdata}, '0);
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    rstn = 1'b1;
    do_txn(0, 1, 0, 1'b0, 0, -1);
    do_txn(1, 1, 0, 1'b0, 0, -1);

    // randomized traffic against a transaction-level model
    clear_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rrm = 0;
    for (int m = 0; m < NM; m++) pend[m] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      any = 0;
      for (int m = 0; m < NM; m++) begin
        if (!pend[m] && $urandom_range(0, 1) == 1) begin
          pend[m] = 1'b1;
          set_req(m, IDB'($urandom), $urandom, $urandom_range(0, 7));
        end
        if (pend[m]) any = 1;
      end
      if (any == 0) begin
        exp_m = $urandom_range(0, NM - 1);
        pend[exp_m] = 1'b1;
        set_req(exp_m, IDB'($urandom), $urandom, $urandom_range(0, 7));
      end
      exp_m = -1;
      for (int k = 0; k < NM; k++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        if (exp_m < 0 && pend[k]) exp_m = k;
`else
        if (exp_m < 0 && pend[(rrm + k) % NM]) exp_m = (rrm + k) % NM;
`endif
      end
      do_txn(exp_m, 1, $urandom_range(0, 3), 1'b1, int'($urandom_range(0, 255)), -1);
      pend[exp_m] = 1'b0;
      rrm = (exp_m + 1) % NM;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
